// File: rtl/muldiv_seq_32_pkg.sv
// ============================================================================
// Module   : muldiv_seq_32_pkg
// Brief    : Shared types and constants for the sequential 32-bit mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_seq_32_pkg;

    localparam int DATA_W      = 32;
    localparam int CNT_W       = 6;
    localparam int MULDIV_ITER = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULDIV_ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : muldiv_seq_32_pkg

`default_nettype wire

// File: rtl/muldiv_seq_32_if.sv
// ============================================================================
// Module   : muldiv_seq_32_if
// Brief    : Request/response bundle between the control unit and muldiv_seq_32.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_seq_32_if;
    import muldiv_seq_32_pkg::*;

    logic              start;
    logic              op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              dbz;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, dbz
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, dbz
    );

endinterface : muldiv_seq_32_if

`default_nettype wire

// File: rtl/muldiv_seq_32_add_sub.sv
// ============================================================================
// Module   : muldiv_seq_32_add_sub
// Brief    : 32-bit ripple-carry adder/subtractor (i_sna=1 computes a - b).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq_32_add_sub
    import muldiv_seq_32_pkg::*;
(
    input  wire logic [DATA_W-1:0] i_a,
    input  wire logic [DATA_W-1:0] i_b,
    input  wire logic              i_sna,
    output logic      [DATA_W-1:0] o_sum,
    output logic                   o_co
);

    logic [DATA_W:0] w_c;

    assign w_c[0] = i_sna;

    // Carry-out of a subtract is the inverted borrow: 1 means a >= b.
    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        logic w_bx;
        assign w_bx       = i_b[i] ^ i_sna;
        assign o_sum[i]   = i_a[i] ^ w_bx ^ w_c[i];
        assign w_c[i+1]   = (i_a[i] & w_bx) | (w_c[i] & (i_a[i] ^ w_bx));
    end

    assign o_co = w_c[DATA_W];

endmodule : muldiv_seq_32_add_sub

`default_nettype wire

// File: rtl/muldiv_seq_32.sv
// ============================================================================
// Module   : muldiv_seq_32
// Brief    : Sequential unsigned 32x32 shift-add multiply / restoring divide,
//            one shared adder step per cycle. Optional macro MULDIV_DBZ_EN
//            enables early divide-by-zero completion and the dbz flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq_32
    import muldiv_seq_32_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    muldiv_seq_32_if.slave  bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [DATA_W-1:0]  hi_q,    hi_d;
    logic [DATA_W-1:0]  lo_q,    lo_d;
    logic [DATA_W-1:0]  m_q,     m_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
`ifdef MULDIV_DBZ_EN
    logic               dbz_q,   dbz_d;
`endif

    logic [DATA_W-1:0]  w_rem;
    logic [DATA_W-1:0]  w_add_a;
    logic [DATA_W-1:0]  w_add_b;
    logic               w_add_sna;
    logic [DATA_W-1:0]  w_sum;
    logic               w_co;

    // Partial remainder shifted left; hi_q[31] is its implicit bit 32.
    assign w_rem = {hi_q[DATA_W-2:0], lo_q[DATA_W-1]};

    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_sna = 1'b0;
        case (state_q)
            ST_MUL: begin
                w_add_a = hi_q;
                w_add_b = m_q;
            end
            ST_DIV: begin
                w_add_a   = w_rem;
                w_add_b   = m_q;
                w_add_sna = 1'b1;
            end
            default: ;
        endcase
    end

    muldiv_seq_32_add_sub u_add_sub (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_sna (w_add_sna),
        .o_sum (w_sum),
        .o_co  (w_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
`ifdef MULDIV_DBZ_EN
        dbz_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    hi_d    = '0;
                    lo_d    = bus.a;
                    m_d     = bus.b;
                    cnt_d   = '0;
                    state_d = (bus.op == OP_DIV) ? ST_DIV : ST_MUL;
`ifdef MULDIV_DBZ_EN
                    if (bus.op == OP_DIV && bus.b == '0) begin
                        state_d = ST_DONE;
                        hi_d    = bus.a;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (lo_q[0]) begin
                    {hi_d, lo_d} = {w_co, w_sum, lo_q[DATA_W-1:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi_q, lo_q[DATA_W-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                if (hi_q[DATA_W-1] || w_co) begin
                    hi_d = w_sum;
                    lo_d = {lo_q[DATA_W-2:0], 1'b1};
                end else begin
                    hi_d = w_rem;
                    lo_d = {lo_q[DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_MUL) || (state_d == ST_DIV);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULDIV_DBZ_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MULDIV_DBZ_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
`ifdef MULDIV_DBZ_EN
    assign bus.dbz  = dbz_q;
`else
    assign bus.dbz  = 1'b0;
`endif

endmodule : muldiv_seq_32

`default_nettype wire
